// File: rtl/panel_image_loader_if.sv
// Byte-stream input and image-store write bus of the panel image loader.
// The slave side is the loader; the master side feeds bytes and receives writes.
interface panel_image_loader_if #(
  parameter int SLOT_W = 2,
  parameter int ADDR_W = 12
);
  logic [7:0]               in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     wr_en;
  logic [SLOT_W+ADDR_W-1:0] wr_addr;
  logic [23:0]              wr_data;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );
endinterface

// File: rtl/panel_image_loader.sv
// Assembles a framed R,G,B byte stream into 24-bit pixel writes for one image slot
// and commits the slot only once the trailer checksum matches.
module panel_image_loader #(
  parameter int         PIXELS         = 4096,
  parameter int         ADDR_W         = 12,
  parameter int         SLOT_W         = 2,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  panel_image_loader_if.slave io_bus,
  output logic              o_busy,
  output logic              o_load_done,
  output logic              o_load_err,
  output logic [1:0]        o_err_code,
  output logic [SLOT_W-1:0] o_load_slot
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(PIXELS - 1);

  localparam logic [1:0] ERR_SLOT  = 2'd1;
  localparam logic [1:0] ERR_CKSUM = 2'd2;
  localparam logic [1:0] ERR_TMO   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SLOT,
    S_PIXEL,
    S_CKSUM
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [TMO_W-1:0]         r_tmo;
  logic [7:0]               r_cksum;
  logic [SLOT_W-1:0]        r_slot;
  logic [ADDR_W-1:0]        r_idx;
  logic [1:0]               r_phase;
  logic [7:0]               r_red;
  logic [7:0]               r_grn;
  logic                     r_wr_en_p1;
  logic [SLOT_W+ADDR_W-1:0] r_wr_addr_p1;
  logic [23:0]              r_wr_data_p1;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_err;
  logic [1:0]               r_err_code;
  logic [SLOT_W-1:0]        r_load_slot;

  logic w_ready;
  logic w_acc;
  logic w_start;
  logic w_slot_ok;
  logic w_slot_bad;
  logic w_px_acc;
  logic w_px_wr;
  logic w_ck_good;
  logic w_ck_bad;
  logic w_tmo;

  function automatic logic [7:0] f_cksum_add(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  function automatic logic f_slot_ok(input logic [7:0] b);
    return (b >> SLOT_W) == 8'd0;
  endfunction

  // Every byte is consumed in one cycle, so readiness only depends on reset.
  assign w_ready         = !rst;
  assign w_acc           = io_bus.in_valid && w_ready;
  assign io_bus.in_ready = w_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_slot_ok  = 1'b0;
    w_slot_bad = 1'b0;
    w_px_acc   = 1'b0;
    w_px_wr    = 1'b0;
    w_ck_good  = 1'b0;
    w_ck_bad   = 1'b0;
    w_tmo      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc && io_bus.in_data == SYNC_BYTE) begin
          w_start = 1'b1;
          w_next  = S_SLOT;
        end
      end
      S_SLOT: begin
        if (w_acc) begin
          if (f_slot_ok(io_bus.in_data)) begin
            w_slot_ok = 1'b1;
            w_next    = S_PIXEL;
          end else begin
            w_slot_bad = 1'b1;
            w_next     = S_IDLE;
          end
        end
      end
      S_PIXEL: begin
        if (w_acc) begin
          w_px_acc = 1'b1;
          if (r_phase == 2'd2) begin
            w_px_wr = 1'b1;
            if (r_idx == IDX_LAST) begin
              w_next = S_CKSUM;
            end
          end
        end
      end
      S_CKSUM: begin
        if (w_acc) begin
          if (io_bus.in_data == r_cksum) begin
            w_ck_good = 1'b1;
          end else begin
            w_ck_bad = 1'b1;
          end
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // An idle cycle with the counter already at its limit abandons the frame.
    if (r_state != S_IDLE && !w_acc && r_tmo == TMO_LAST) begin
      w_tmo  = 1'b1;
      w_next = S_IDLE;
    end
  end

  // Stage p0: byte capture, checksum accumulation and pixel assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo   <= '0;
      r_cksum <= '0;
      r_slot  <= '0;
      r_idx   <= '0;
      r_phase <= '0;
      r_red   <= '0;
      r_grn   <= '0;
    end else begin
      if (r_state == S_IDLE || w_acc || w_tmo) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + 1'b1;
      end

      if (w_start) begin
        r_cksum <= '0;
      end else if (w_slot_ok || w_px_acc) begin
        r_cksum <= f_cksum_add(r_cksum, io_bus.in_data);
      end

      if (w_slot_ok) begin
        r_slot  <= io_bus.in_data[SLOT_W-1:0];
        r_idx   <= '0;
        r_phase <= '0;
      end else if (w_px_acc) begin
        case (r_phase)
          2'd0: begin
            r_red   <= io_bus.in_data;
            r_phase <= 2'd1;
          end
          2'd1: begin
            r_grn   <= io_bus.in_data;
            r_phase <= 2'd2;
          end
          default: begin
            r_phase <= 2'd0;
            if (r_idx != IDX_LAST) begin
              r_idx <= r_idx + 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Stage p1: registered memory write and frame status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en_p1   <= 1'b0;
      r_wr_addr_p1 <= '0;
      r_wr_data_p1 <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= '0;
      r_load_slot  <= '0;
    end else begin
      r_wr_en_p1 <= w_px_wr;
      if (w_px_wr) begin
        r_wr_addr_p1 <= {r_slot, r_idx};
        r_wr_data_p1 <= {r_red, r_grn, io_bus.in_data};
      end

      r_done <= w_ck_good;
      r_err  <= w_slot_bad || w_ck_bad || w_tmo;

      if (w_slot_bad) begin
        r_err_code <= ERR_SLOT;
      end else if (w_ck_bad) begin
        r_err_code <= ERR_CKSUM;
      end else if (w_tmo) begin
        r_err_code <= ERR_TMO;
      end

      if (w_ck_good) begin
        r_load_slot <= r_slot;
      end

      if (w_start) begin
        r_busy <= 1'b1;
      end else if (w_ck_good || w_ck_bad || w_slot_bad || w_tmo) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign io_bus.wr_en   = r_wr_en_p1;
  assign io_bus.wr_addr = r_wr_addr_p1;
  assign io_bus.wr_data = r_wr_data_p1;
  assign o_busy         = r_busy;
  assign o_load_done    = r_done;
  assign o_load_err     = r_err;
  assign o_err_code     = r_err_code;
  assign o_load_slot    = r_load_slot;

endmodule

// File: tb/tb_panel_image_loader.sv
// Directed-plus-random bench for panel_image_loader: frames are built from byte
// queues and expected writes/checksums are derived arithmetically from them.
module tb_panel_image_loader;
  localparam int         PIXELS = 4096;
  localparam int         ADDR_W = 12;
  localparam int         SLOT_W = 2;
  localparam int         TMO    = 64;
  localparam logic [7:0] SYNC   = 8'hA5;
  localparam int         AW     = SLOT_W + ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  panel_image_loader_if #(.SLOT_W(SLOT_W), .ADDR_W(ADDR_W)) bus ();

  logic              busy;
  logic              load_done;
  logic              load_err;
  logic [1:0]        err_code;
  logic [SLOT_W-1:0] load_slot;

  panel_image_loader #(
    .PIXELS(PIXELS), .ADDR_W(ADDR_W), .SLOT_W(SLOT_W),
    .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_bus(bus),
    .o_busy(busy),
    .o_load_done(load_done),
    .o_load_err(load_err),
    .o_err_code(err_code),
    .o_load_slot(load_slot)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int edge_no = 0;
  int last_acc = 0;

  logic [AW-1:0] cap_addr[$];
  logic [23:0]   cap_data[$];
  int n_done, n_err, err_edge;
  int n_overlap = 0;
  int n_busy_pulse = 0;

  logic [7:0]    pay[$];
  logic [AW-1:0] exp_addr[$];
  logic [23:0]   exp_data[$];

  always @(posedge clk) edge_no <= edge_no + 1;

  always @(negedge clk) begin
    if (bus.wr_en) begin
      cap_addr.push_back(bus.wr_addr);
      cap_data.push_back(bus.wr_data);
    end
    if (load_done) n_done++;
    if (load_err) begin
      n_err++;
      err_edge = edge_no;
    end
    if (load_done && load_err) n_overlap++;
    if ((load_done || load_err) && busy) n_busy_pulse++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    cap_addr.delete();
    cap_data.delete();
    n_done = 0;
    n_err = 0;
    err_edge = -1;
  endtask

  task automatic build_pattern();
    pay.delete();
    for (int n = 0; n < PIXELS; n++) begin
      pay.push_back(8'(n));
      pay.push_back(8'h00);
      pay.push_back(8'hFF);
    end
  endtask

  task automatic build_random(input int nbytes);
    pay.delete();
    for (int i = 0; i < nbytes; i++) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  // Only complete R,G,B triples become writes, at slot*PIXELS + pixel number.
  task automatic build_expect(input int slot);
    exp_addr.delete();
    exp_data.delete();
    for (int n = 0; 3 * n + 2 < pay.size(); n++) begin
      exp_addr.push_back(AW'(slot * PIXELS + n));
      exp_data.push_back({pay[3*n], pay[3*n+1], pay[3*n+2]});
    end
  endtask

  function automatic logic [7:0] cksum(input int slot);
    int sum = slot;
    foreach (pay[i]) sum += int'(pay[i]);
    return 8'(sum % 256);
  endfunction

  task automatic send(input logic [7:0] b);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    last_acc     = edge_no;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] slot_b, input logic [7:0] trailer, input bit gapped);
    send(SYNC);
    send(slot_b);
    chk("busy_in_frame", 32'(busy), 32'd1);
    foreach (pay[i]) begin
      if (gapped && i == 600) idle(TMO - 1);
      else if (gapped && $urandom_range(0, 7) == 0) idle($urandom_range(1, 5));
      send(pay[i]);
    end
    send(trailer);
  endtask

  task automatic check_writes(input string tag);
    int f0;
    chk({tag, "_count"}, 32'(cap_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size(); i++) begin
      f0 = n_fail;
      chk({tag, "_addr"}, 32'(cap_addr[i]), 32'(exp_addr[i]));
      chk({tag, "_data"}, 32'(cap_data[i]), 32'(exp_data[i]));
      if (n_fail != f0) break;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(load_done), 32'd0);
    chk({tag, "_err"}, 32'(load_err), 32'd0);
    chk({tag, "_err_code"}, 32'(err_code), 32'd0);
    chk({tag, "_load_slot"}, 32'(load_slot), 32'd0);
  endtask

  initial begin
    int start;
    logic [7:0] junk;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    clear_mon();

    // Reset state
    idle(3);
    check_reset_outputs("rst");
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);
    idle(2);

    // Good load into slot 2
    clear_mon();
    build_pattern();
    build_expect(2);
    send_frame(8'h02, cksum(2), 1'b0);
    idle(4);
    check_writes("good");
    chk("good_first_addr", 32'(cap_addr[0]), 32'h2000);
    chk("good_last_addr", 32'(cap_addr[PIXELS-1]), 32'h2FFF);
    chk("good_idx5_data", 32'(cap_data[5]), 32'h0500FF);
    chk("good_done", 32'(n_done), 32'd1);
    chk("good_err", 32'(n_err), 32'd0);
    chk("good_slot", 32'(load_slot), 32'd2);
    chk("good_busy", 32'(busy), 32'd0);

    // Bad checksum into slot 1
    clear_mon();
    build_expect(1);
    send_frame(8'h01, cksum(1) ^ 8'h01, 1'b0);
    idle(4);
    check_writes("badck");
    chk("badck_err", 32'(n_err), 32'd1);
    chk("badck_done", 32'(n_done), 32'd0);
    chk("badck_code", 32'(err_code), 32'd2);
    chk("badck_slot", 32'(load_slot), 32'd2);
    chk("badck_busy", 32'(busy), 32'd0);

    // Bad slot byte
    clear_mon();
    send(SYNC);
    send(8'h04);
    idle(4);
    chk("badslot_err", 32'(n_err), 32'd1);
    chk("badslot_code", 32'(err_code), 32'd1);
    chk("badslot_writes", 32'(cap_addr.size()), 32'd0);
    chk("badslot_busy", 32'(busy), 32'd0);

    // Slot 0 frame right after is accepted, then times out
    clear_mon();
    build_random(7);
    build_expect(0);
    send(SYNC);
    send(8'h00);
    chk("slot0_busy", 32'(busy), 32'd1);
    foreach (pay[i]) send(pay[i]);
    start = last_acc;
    idle(TMO + 4);
    check_writes("slot0");
    chk("slot0_err_edge", 32'(err_edge), 32'(start + TMO));
    chk("slot0_code", 32'(err_code), 32'd3);

    // Timeout in slot 3, with sync values carried as pixel data
    clear_mon();
    build_random(7);
    pay[0] = SYNC;
    pay[3] = SYNC;
    build_expect(3);
    send(SYNC);
    send(8'h03);
    foreach (pay[i]) send(pay[i]);
    start = last_acc;
    idle(TMO + 4);
    check_writes("tmo");
    chk("tmo_err_cnt", 32'(n_err), 32'd1);
    chk("tmo_err_edge", 32'(err_edge), 32'(start + TMO));
    chk("tmo_code", 32'(err_code), 32'd3);
    chk("tmo_busy", 32'(busy), 32'd0);
    chk("tmo_slot", 32'(load_slot), 32'd2);

    // Junk bytes, then a gapped slot 2 frame including one maximum-length gap
    clear_mon();
    for (int i = 0; i < 10; i++) begin
      junk = 8'($urandom_range(0, 255));
      if (junk == SYNC) junk = 8'h5A;
      idle($urandom_range(0, 3));
      send(junk);
    end
    chk("junk_busy", 32'(busy), 32'd0);
    build_pattern();
    build_expect(2);
    send_frame(8'h02, cksum(2), 1'b1);
    idle(4);
    check_writes("gap");
    chk("gap_done", 32'(n_done), 32'd1);
    chk("gap_err", 32'(n_err), 32'd0);
    chk("gap_slot", 32'(load_slot), 32'd2);

    // Reset during pixel 100
    clear_mon();
    build_random(3 * PIXELS);
    send(SYNC);
    send(8'h03);
    for (int i = 0; i < 3 * 100 + 1; i++) send(pay[i]);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    idle(2);
    rst = 1'b0;
    idle(2);

    // Fresh frame after reset into slot 1
    clear_mon();
    build_random(3 * PIXELS);
    build_expect(1);
    send_frame(8'h01, cksum(1), 1'b0);
    idle(4);
    check_writes("fresh");
    chk("fresh_done", 32'(n_done), 32'd1);
    chk("fresh_err", 32'(n_err), 32'd0);
    chk("fresh_slot", 32'(load_slot), 32'd1);
    chk("fresh_code", 32'(err_code), 32'd0);

    chk("done_err_overlap", 32'(n_overlap), 32'd0);
    chk("busy_at_pulse", 32'(n_busy_pulse), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
